// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Includes the ALU result skid entry and branch kinds.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam int SKID_DEPTH_LOG = 1;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2,
    BR_RSVD = 2'd3
  } br_t;

  typedef struct packed {
    word_t    result;
    logic     neg;
    regbits_t rd;
    logic     br_taken;
    logic     ovf;
  } skid_entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  function automatic logic br_resolve(
    input br_t  t,
    input logic z
  );
    logic tk;
    tk = 1'b0;
    unique case (t)
      BR_EQ:   tk = z;
      BR_NE:   tk = !z;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/alu_result_skid.sv
// Two-entry ALU result skid buffer at the EX/MEM boundary.
// Resolves branch outcome and signed-overflow traps on capture.
module alu_result_skid
  import cpu_types_pkg::*;
#(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  word_t                alu_out,
  input  logic                 neg_flag,
  input  logic                 zero_flag,
  input  logic                 of_flag,
  input  logic                 chk_ov,
  input  br_t                  br_type,
  input  regbits_t             rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output word_t                out_result,
  output logic                 out_neg,
  output regbits_t             out_rd,
  output logic                 out_br_taken,
  output logic                 out_ovf,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

  occ_t                 state_q, state_d;
  skid_entry_t          head_q;
  skid_entry_t          skid_q;
  skid_entry_t          new_e;
  logic                 in_ready_q;
  logic [OVF_CNT_W-1:0] cnt_q;
  logic                 acc;
  logic                 pop;
  logic                 ovf_in;

  always_comb begin
    acc    = in_valid && in_ready_q && !flush;
    pop    = (state_q != S_EMPTY) && out_ready && !flush;
    ovf_in = chk_ov && of_flag;

    new_e          = '0;
    new_e.result   = alu_out;
    new_e.neg      = neg_flag;
    new_e.rd       = ovf_in ? '0 : rd;
    new_e.br_taken = br_resolve(br_type, zero_flag);
    new_e.ovf      = ovf_in;

    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: if (acc) state_d = S_ONE;
        S_ONE: begin
          if (acc && !pop)      state_d = S_TWO;
          else if (!acc && pop) state_d = S_EMPTY;
        end
        S_TWO:   if (pop) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);

      // Head reloads straight from the ALU when it drains in the same cycle.
      if (!flush) begin
        unique case (state_q)
          S_EMPTY: if (acc) head_q <= new_e;
          S_ONE: begin
            if (acc && pop) head_q <= new_e;
            else if (acc)   skid_q <= new_e;
          end
          S_TWO:   if (pop) head_q <= skid_q;
          default: ;
        endcase
      end

      if (acc && ovf_in && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != S_EMPTY);
  assign out_result   = head_q.result;
  assign out_neg      = head_q.neg;
  assign out_rd       = head_q.rd;
  assign out_br_taken = head_q.br_taken;
  assign out_ovf      = head_q.ovf;
  assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed bench for alu_result_skid.
// Scoreboard queue of expected entries, popped as the head drains.
module tb_alu_result_skid;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic        neg_flag;
  logic        zero_flag;
  logic        of_flag;
  logic        chk_ov;
  br_t         br_type;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_neg;
  logic [4:0]  out_rd;
  logic        out_br_taken;
  logic        out_ovf;
  logic [7:0]  ovf_count;

  typedef struct {
    logic [31:0] res;
    logic        neg;
    logic [4:0]  rd;
    logic        br;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   occ;
  int   exp_cnt;
  int   checks;
  int   errors;
  logic accepted;

  alu_result_skid #(.OVF_CNT_W(8)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_out      (alu_out),
    .neg_flag     (neg_flag),
    .zero_flag    (zero_flag),
    .of_flag      (of_flag),
    .chk_ov       (chk_ov),
    .br_type      (br_type),
    .rd           (rd),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_neg      (out_neg),
    .out_rd       (out_rd),
    .out_br_taken (out_br_taken),
    .out_ovf      (out_ovf),
    .ovf_count    (ovf_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk();
    exp_t e;
    e.ovf = chk_ov & of_flag;
    e.res = alu_out;
    e.neg = neg_flag;
    e.rd  = e.ovf ? 5'd0 : rd;
    e.br  = ((br_type == 2'd1) && zero_flag) ||
            ((br_type == 2'd2) && !zero_flag);
    return e;
  endfunction

  task automatic step();
    logic acc;
    logic pop;
    chk("out_valid", 32'(out_valid), 32'(occ != 0));
    chk("in_ready", 32'(in_ready), 32'(occ != 2));
    chk("ovf_count", 32'(ovf_count), exp_cnt);
    if (occ != 0 && sbq.size() > 0) begin
      chk("out_result", out_result, sbq[0].res);
      chk("out_neg", 32'(out_neg), 32'(sbq[0].neg));
      chk("out_rd", 32'(out_rd), 32'(sbq[0].rd));
      chk("out_br_taken", 32'(out_br_taken), 32'(sbq[0].br));
      chk("out_ovf", 32'(out_ovf), 32'(sbq[0].ovf));
    end
    pop = (occ != 0) && out_ready && !flush;
    acc = in_valid && (occ != 2) && !flush;
    if (flush) begin
      occ = 0;
      sbq.delete();
    end else begin
      if (pop) void'(sbq.pop_front());
      if (acc) begin
        sbq.push_back(mk());
        if ((chk_ov & of_flag) && exp_cnt != 255) exp_cnt++;
      end
      occ = occ - int'(pop) + int'(acc);
    end
    accepted = acc;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive(input logic [31:0] v, input logic n,
                       input logic z, input logic o, input logic c,
                       input logic [1:0] b, input logic [4:0] r);
    in_valid  = 1'b1;
    alu_out   = v;
    neg_flag  = n;
    zero_flag = z;
    of_flag   = o;
    chk_ov    = c;
    br_type   = br_t'(b);
    rd        = r;
  endtask

  task automatic send(input logic [31:0] v, input logic n,
                      input logic z, input logic o, input logic c,
                      input logic [1:0] b, input logic [4:0] r);
    int k;
    drive(v, n, z, o, c, b, r);
    k = 0;
    do begin
      step();
      k++;
    end while (!accepted && k < 20);
    chk("accept", 32'(accepted), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (occ != 0 && k < 20) begin
      step();
      k++;
    end
    chk("drained", 32'(occ), 32'd0);
    step();
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(ovf_count), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_neg", 32'(out_neg), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_br", 32'(out_br_taken), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; occ = 0; exp_cnt = 0;
    accepted = 1'b0;
    in_valid = 1'b0; alu_out = '0; neg_flag = 0; zero_flag = 0;
    of_flag = 0; chk_ov = 0; br_type = BR_NONE; rd = '0;
    flush = 1'b0; out_ready = 1'b0;
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk_reset_vals();
    nRST = 1'b1;
    @(negedge CLK);

    // single pass-through
    out_ready = 1'b1;
    send(32'h5, 0, 0, 0, 0, 2'd0, 5'd3);
    drain();

    // backpressure: A, B fill, C held off
    out_ready = 1'b0;
    send(32'h1, 0, 0, 0, 0, 2'd0, 5'd1);
    send(32'h2, 0, 0, 0, 0, 2'd0, 5'd2);
    drive(32'h3, 0, 0, 0, 0, 2'd0, 5'd4);
    step();
    chk("c_held", 32'(accepted), 32'd0);
    step();
    out_ready = 1'b1;
    send(32'h3, 0, 0, 0, 0, 2'd0, 5'd4);
    drain();

    // branch resolution and negative flag
    send(32'h10, 1, 1, 0, 0, 2'd1, 5'd5);
    send(32'h11, 0, 1, 0, 0, 2'd2, 5'd6);
    send(32'h12, 0, 1, 0, 0, 2'd3, 5'd7);
    send(32'h13, 1, 0, 0, 0, 2'd2, 5'd8);
    send(32'h14, 0, 0, 1, 0, 2'd1, 5'd9);
    drain();

    // overflow trap, then saturation
    send(32'h8000_0000, 1, 0, 1, 1, 2'd0, 5'd9);
    drain();
    chk("ovf_one", 32'(ovf_count), 32'd1);
    for (int i = 0; i < 300; i++)
      send($urandom, 1'($urandom), 0, 1, 1, 2'd0, 5'($urandom));
    drain();
    chk("ovf_sat", 32'(ovf_count), 32'd255);

    // flush with two entries and a live input
    out_ready = 1'b0;
    send(32'hA, 0, 0, 0, 0, 2'd0, 5'd10);
    send(32'hB, 0, 0, 0, 0, 2'd0, 5'd11);
    drive(32'hC, 0, 0, 1, 1, 2'd0, 5'd12);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);

    // async reset mid-drain
    send(32'h21, 0, 0, 0, 0, 2'd0, 5'd1);
    send(32'h22, 0, 0, 0, 0, 2'd0, 5'd2);
    out_ready = 1'b1;
    step();
    #2 nRST = 1'b0;
    #1 chk_reset_vals();
    occ = 0; exp_cnt = 0; sbq.delete();
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    send(32'h77, 0, 1, 0, 0, 2'd1, 5'd13);
    in_valid = 1'b0;
    step();
    chk("post_rst_lat", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
